// File: rtl/exec_wb_skid.sv
// Two-entry skid buffer carrying execute results to write-back with every WB-facing output registered.
// Define EXEC_WB_SKID_FWD_EN to add the registered fwd_* copy of the entry popped on the previous edge.
module exec_wb_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  commit_cnt
`ifdef EXEC_WB_SKID_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] skid_addr;
  logic [DATA_W-1:0] skid_data;

  logic accept;
  logic push;
  logic pop;

  // Results for register 0 complete the handshake but are never stored.
  assign accept    = ex_valid & ex_ready;
  assign push      = accept & (ex_addr != '0);
  assign pop       = wb_valid & wb_ready;
  assign occupancy = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      ex_ready   <= 1'b1;
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      skid_addr  <= '0;
      skid_data  <= '0;
      commit_cnt <= '0;
    end else begin
      if (pop) begin
        commit_cnt <= commit_cnt + CNT_W'(1);
      end
      case (state)
        EMPTY: begin
          if (push) begin
            wb_addr  <= ex_addr;
            wb_data  <= ex_data;
            wb_valid <= 1'b1;
            state    <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            wb_addr <= ex_addr;
            wb_data <= ex_data;
          end else if (push) begin
            skid_addr <= ex_addr;
            skid_data <= ex_data;
            ex_ready  <= 1'b0;
            state     <= TWO;
          end else if (pop) begin
            wb_valid <= 1'b0;
            state    <= EMPTY;
          end
        end
        TWO: begin
          // ex_ready is low here, so only a pop can move the state.
          if (pop) begin
            wb_addr  <= skid_addr;
            wb_data  <= skid_data;
            ex_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state    <= EMPTY;
          wb_valid <= 1'b0;
          ex_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef EXEC_WB_SKID_FWD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_data  <= '0;
    end else begin
      fwd_valid <= pop;
      if (pop) begin
        fwd_addr <= wb_addr;
        fwd_data <= wb_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exec_wb_skid.sv
// Bench for exec_wb_skid: vector table plus FIFO scoreboard; covers fwd_* when EXEC_WB_SKID_FWD_EN is defined.
module tb_exec_wb_skid;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [4:0]  ex_addr = '0;
  logic [31:0] ex_data = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [1:0]  occupancy;
  logic [15:0] commit_cnt;
`ifdef EXEC_WB_SKID_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
`endif

  exec_wb_skid #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_data(ex_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .occupancy(occupancy), .commit_cnt(commit_cnt)
`ifdef EXEC_WB_SKID_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic        r;
    logic        e_wbv;
    logic [1:0]  e_occ;
    logic        e_rdy;
    logic [4:0]  e_addr;
  } vec_t;

  vec_t        vecs [11];
  logic [36:0] exp_q [$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] model_cnt = '0;
  logic        prev_pop = 1'b0;
  logic [36:0] prev_ent = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle; scoreboard sampling happens on the falling edge before the handshake edge.
  task automatic cyc(input logic v, input logic [4:0] a, input logic [31:0] d, input logic r);
    logic [36:0] e;
    ex_valid = v;
    ex_addr  = a;
    ex_data  = d;
    wb_ready = r;
    @(negedge clk);
`ifdef EXEC_WB_SKID_FWD_EN
    chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, prev_pop});
    if (prev_pop) begin
      chk("fwd_addr", {27'd0, fwd_addr}, {27'd0, prev_ent[36:32]});
      chk("fwd_data", fwd_data, prev_ent[31:0]);
    end
`endif
    prev_pop = wb_valid && wb_ready;
    if (prev_pop) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
        prev_ent = '0;
      end else begin
        e = exp_q.pop_front();
        prev_ent = e;
        chk("sb_addr", {27'd0, wb_addr}, {27'd0, e[36:32]});
        chk("sb_data", wb_data, e[31:0]);
      end
      model_cnt = model_cnt + 16'd1;
    end
    if (ex_valid && ex_ready && ex_addr != 5'd0) exp_q.push_back({ex_addr, ex_data});
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 1'b1, 2'd1, 1'b1, 5'd3};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 2'd0, 1'b1, 5'd0};
    vecs[2]  = '{1'b1, 5'd1, 32'h11,       1'b0, 1'b1, 2'd1, 1'b1, 5'd1};
    vecs[3]  = '{1'b1, 5'd2, 32'h22,       1'b0, 1'b1, 2'd2, 1'b0, 5'd1};
    vecs[4]  = '{1'b1, 5'd9, 32'h99,       1'b0, 1'b1, 2'd2, 1'b0, 5'd1};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 2'd1, 1'b1, 5'd2};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 2'd0, 1'b1, 5'd0};
    vecs[7]  = '{1'b1, 5'd0, 32'h55,       1'b1, 1'b0, 2'd0, 1'b1, 5'd0};
    vecs[8]  = '{1'b1, 5'd4, 32'h44,       1'b0, 1'b1, 2'd1, 1'b1, 5'd4};
    vecs[9]  = '{1'b1, 5'd0, 32'h55,       1'b0, 1'b1, 2'd1, 1'b1, 5'd4};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 2'd0, 1'b1, 5'd0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("rst_commit_cnt", {16'd0, commit_cnt}, 32'd0);
    chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);

    for (int i = 0; i < 11; i++) begin
      cyc(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].r);
      chk($sformatf("v%0d_wb_valid", i), {31'd0, wb_valid}, {31'd0, vecs[i].e_wbv});
      chk($sformatf("v%0d_occupancy", i), {30'd0, occupancy}, {30'd0, vecs[i].e_occ});
      chk($sformatf("v%0d_ex_ready", i), {31'd0, ex_ready}, {31'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d_commit_cnt", i), {16'd0, commit_cnt}, {16'd0, model_cnt});
      if (vecs[i].e_wbv) chk($sformatf("v%0d_wb_addr", i), {27'd0, wb_addr}, {27'd0, vecs[i].e_addr});
    end
    chk("after_table_commit", {16'd0, commit_cnt}, 32'd4);

    // Streaming at occupancy 1: addr 1 primes the head, 2..10 push while popping.
    cyc(1'b1, 5'd1, 32'h100, 1'b0);
    for (int i = 2; i <= 10; i++) begin
      cyc(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1);
      chk($sformatf("stream%0d_occupancy", i), {30'd0, occupancy}, 32'd1);
    end
    cyc(1'b0, 5'd0, 32'h0, 1'b1);
    chk("stream_commit_cnt", {16'd0, commit_cnt}, 32'd14);
    chk("stream_drained", {30'd0, occupancy}, 32'd0);

    // Run the counter up to its last value, then one more pop must wrap it.
    cyc(1'b1, 5'd7, 32'h7000, 1'b0);
    for (int k = 0; k < 70000 && model_cnt != 16'hFFFF; k++) begin
      cyc(1'b1, 5'((k % 31) + 1), 32'(k), 1'b1);
    end
    chk("pre_wrap_commit_cnt", {16'd0, commit_cnt}, 32'h0000FFFF);
    cyc(1'b0, 5'd0, 32'h0, 1'b1);
    chk("wrap_commit_cnt", {16'd0, commit_cnt}, 32'd0);
    chk("wrap_occupancy", {30'd0, occupancy}, 32'd0);

    // Asynchronous reset while full.
    cyc(1'b1, 5'd5, 32'h5555, 1'b0);
    cyc(1'b1, 5'd6, 32'h6666, 1'b0);
    chk("full_occupancy", {30'd0, occupancy}, 32'd2);
    chk("full_ex_ready", {31'd0, ex_ready}, 32'd0);
    ex_valid = 1'b1;
    ex_addr  = 5'd7;
    ex_data  = 32'h7777;
    wb_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("arst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("arst_commit_cnt", {16'd0, commit_cnt}, 32'd0);
    exp_q.delete();
    model_cnt = '0;
    prev_pop = 1'b0;
    @(posedge clk);
    #1;
    chk("in_rst_occupancy", {30'd0, occupancy}, 32'd0);
    ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("post_rst_occupancy", {30'd0, occupancy}, 32'd0);

    cyc(1'b1, 5'd12, 32'hCAFE0012, 1'b1);
    cyc(1'b0, 5'd0, 32'h0, 1'b1);
    cyc(1'b0, 5'd0, 32'h0, 1'b0);
    chk("final_commit_cnt", {16'd0, commit_cnt}, 32'd1);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
